// File: rtl/branch_pkg.sv
// Shared constants and types for the branch sequencer.
package branch_pkg;

   // Branch opcodes accepted by the sequencer
   localparam logic [5:0] OpBeq = 6'h04;
   localparam logic [5:0] OpBne = 6'h05;
   localparam logic [5:0] OpBle = 6'h06;
   localparam logic [5:0] OpBgt = 6'h07;

   // Condition-selector codes
   localparam logic [1:0] UcBeq = 2'b00;
   localparam logic [1:0] UcBne = 2'b01;
   localparam logic [1:0] UcBle = 2'b10;
   localparam logic [1:0] UcBgt = 2'b11;

   // ALU operation codes
   localparam logic [2:0] AluCmp  = 3'b111;
   localparam logic [2:0] AluNone = 3'b000;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCompare,
      StResolve,
      StDone,
      StErr
   } state_e;

   function automatic logic is_branch(logic [5:0] op);
      return (op == OpBeq) || (op == OpBne) || (op == OpBle) || (op == OpBgt);
   endfunction

   // Map a branch opcode onto its condition-selector code
   function automatic logic [1:0] uc_sel(logic [5:0] op);
      logic [1:0] sel;
      case (op)
         OpBne:   sel = UcBne;
         OpBle:   sel = UcBle;
         OpBgt:   sel = UcBgt;
         default: sel = UcBeq;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at Max once reached.
module sat_counter16 #(
   parameter logic [15:0] Max = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] count
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   // Next count: increment only while enabled and below the ceiling
   always_comb begin
      count_d = count_q;
      if (en && (count_q != Max)) begin
         count_d = count_q + 16'd1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/branch_seq.sv
// Multi-cycle branch sequencer: load operands, compare, resolve, then report done.
module branch_seq
   import branch_pkg::*;
#(
   parameter logic [15:0] SatMax = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic        cond_in,
   output logic        ab_load,
   output logic [2:0]  alu_ctrl,
   output logic        UC_control,
   output logic [1:0]  UC_op,
   output logic        pc_write,
   output logic        pc_src,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [15:0] taken_count
);

   state_e     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic       taken;

   // Next-state and opcode latch; start is only honoured in idle
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (is_branch(opcode)) begin
                  state_d = StLoad;
                  op_d    = opcode;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StLoad:    state_d = StCompare;
         StCompare: state_d = StResolve;
         StResolve: state_d = StDone;
         StDone:    state_d = StIdle;
         StErr:     state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State and latched opcode registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         op_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Moore outputs; the selector stays enabled through resolve because it
   // only holds its last value when disabled, so cond_in stays meaningful.
   always_comb begin
      ab_load    = 1'b0;
      alu_ctrl   = AluNone;
      UC_control = 1'b0;
      UC_op      = 2'b00;
      busy       = (state_q != StIdle);
      done       = 1'b0;
      illegal    = 1'b0;
      unique case (state_q)
         StLoad: ab_load = 1'b1;
         StCompare, StResolve: begin
            alu_ctrl   = AluCmp;
            UC_control = 1'b1;
            UC_op      = uc_sel(op_q);
         end
         StDone: done    = 1'b1;
         StErr:  illegal = 1'b1;
         default: ;
      endcase
   end

   // cond_in is only looked at in resolve
   assign taken    = (state_q == StResolve) && cond_in;
   assign pc_write = taken;
   assign pc_src   = taken;

   sat_counter16 #(
      .Max (SatMax)
   ) u_taken_cnt (
      .clk   (clk),
      .rst_n (reset),
      .en    (taken),
      .count (taken_count)
   );

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
- REQ-001: clk  input  1  processor clock; all state updates on rising edge.
- REQ-002: reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- REQ-003: start  input  1  request to execute the branch instruction whose opcode is presented on opcode.
- REQ-004: opcode  input  6  instruction opcode: BEQ=6'h04, BNE=6'h05, BLE=6'h06, BGT=6'h07.
- REQ-005: cond_in  input  1  branch-condition result returned by the comparator/selector block, 1=taken.
- REQ-006: ab_load  output  1  load operand registers A and B from the register file.
- REQ-007: alu_ctrl  output  3  ALU operation; 3'b111 = compare (drives igual/maior), 3'b000 otherwise.
- REQ-008: UC_control  output  1  enables the condition selector.
- REQ-009: UC_op  output  2  condition select: 00 BEQ, 01 BNE, 10 BLE, 11 BGT.
- REQ-010: pc_write  output  1  write branch target into PC.
- REQ-011: pc_src  output  1  PC mux select, 1=branch target, 0=PC+4.
- REQ-012: busy  output  1  high in every state except IDLE.
- REQ-013: done  output  1  one-cycle completion pulse.
- REQ-014: illegal  output  1  one-cycle pulse: start with a non-branch opcode.
- REQ-015: taken_count  output  16  number of branches taken since reset, saturating.

Function
- REQ-016: FSM states IDLE, LOAD, COMPARE, RESOLVE, DONE, ERR; one state per cycle.
- REQ-017: In IDLE, start=1 with a legal opcode latches opcode and goes to LOAD; start=1 with an illegal opcode goes to ERR; start=0 stays in IDLE.
- REQ-018: start while busy=1 is ignored; opcode changes after acceptance have no effect.
- REQ-019: LOAD: ab_load=1; next state COMPARE.
- REQ-020: COMPARE: alu_ctrl=3'b111, UC_control=1, UC_op=latched code; next state RESOLVE.
- REQ-021: RESOLVE: alu_ctrl=3'b111, UC_control=1, UC_op held; cond_in sampled this cycle; if 1, pc_write=1, pc_src=1, taken_count increments; next state DONE.
- REQ-022: UC_control stays high through RESOLVE because the selector holds its last output when disabled; cond_in is never sampled in any other state.
- REQ-023: DONE: done=1; next state IDLE. ERR: illegal=1; next state IDLE.
- REQ-024: Latency: start accepted at cycle N, pc_write at N+3, done at N+4; a new start is accepted no earlier than N+5.
- REQ-025: All outputs are decoded from the state (Moore), except pc_write/pc_src, which are state AND cond_in in RESOLVE. Outputs not listed for a state are 0.
- REQ-026: taken_count saturates at 16'hFFFF; further taken branches leave it unchanged.
- REQ-027: cond_in=0 in RESOLVE: pc_write=0, pc_src=0, count unchanged, and the FSM still goes through DONE.

Reset
- REQ-028: reset=0 asynchronously forces IDLE, latched opcode to 0 and taken_count to 0, and drives every output to 0.
- REQ-029: Reset asserted mid-sequence aborts it: no pc_write or done follows. After release, the FSM waits for a new start.

Structure
- REQ-030: Shared package branch_pkg holds the opcode constants, UC_op encodings, ALU compare code 3'b111 and the state encoding.
- REQ-031: One sub-module, sat_counter16 (enable, async active-low reset, saturating), implements taken_count.

Verification
- REQ-032: BEQ (6'h04), cond_in=1 at RESOLVE: ab_load at N+1, UC_op=00 with UC_control=1 at N+2..N+3, pc_write=pc_src=1 at N+3, done at N+4, taken_count 0->1.
- REQ-033: BGT (6'h07), cond_in=0: UC_op=11, no pc_write, done at N+4, taken_count unchanged.
- REQ-034: start with opcode 6'h23: illegal=1 at N+1, busy=1 for only that cycle, no UC_control; return to IDLE.
- REQ-035: start pulsed at N+2 with opcode changed to BNE during a BLE sequence: UC_op stays 10 and the second start is ignored.
- REQ-036: reset=0 asserted in COMPARE: all outputs 0 within the same cycle, no done; preload taken_count to 16'hFFFF via repeated taken branches, next taken branch leaves it 16'hFFFF.
